bcd_pulse_counter: RTL and testbench

- Multi-digit BCD up/down counter that consumes the clean single-cycle `pulse` produced by the push-button debouncer stage.
- Each accepted pulse steps the decimal count by exactly one.
- Feeds the 7-segment display driver with packed BCD digits, plus status flags for LEDs.
- Supports synchronous clear, parallel load, and wrap or saturate at the range limits.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_pulse_counter_if.sv | 28 ++
 rtl/bcd_digit.sv | 46 ++++
 rtl/bcd_pulse_counter.sv | 89 ++++++++
 tb/tb_bcd_pulse_counter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble clamp used by the pulse counter and its decades.
package bcd_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_MIN  = 4'd0;

    // Saturate a raw nibble into the legal decimal range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_pulse_counter_if.sv
// Control/data bundle between the debouncer/display glue (master) and the BCD counter (slave).
interface bcd_pulse_counter_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned WIDTH = 4 * DIGITS;

    logic             en;
    logic             up_down;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] bcd;
    logic             carry;
    logic             is_zero;
    logic             is_max;
    logic             load_err;

    modport master (
        output en, up_down, clear, load, load_value,
        input  bcd, carry, is_zero, is_max, load_err
    );

    modport slave (
        input  en, up_down, clear, load, load_value,
        output bcd, carry, is_zero, is_max, load_err
    );

endinterface : bcd_pulse_counter_if

// File: rtl/bcd_digit.sv
// One decimal decade: clear > load > step, rolling 9->0 up and 0->9 down.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       up_down,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       at_max,
    output logic       at_min
);

    logic [3:0] q_next;

    // Next-digit selection; the clamp keeps the register inside 0..9 even on raw load data.
    always_comb begin
        q_next = q;
        if (clear) begin
            q_next = BCD_MIN;
        end else if (load) begin
            q_next = bcd_clamp(d);
        end else if (step) begin
            if (up_down) begin
                q_next = (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q_next = (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else begin
            q <= q_next;
        end
    end

    assign at_max = (q == BCD_MAX);
    assign at_min = (q == BCD_MIN);

endmodule : bcd_digit

// File: rtl/bcd_pulse_counter.sv
// Multi-decade BCD up/down pulse counter with clear, clamped load and wrap/saturate limits.
module bcd_pulse_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_pulse_counter_if.slave  bus
);

    localparam int unsigned WIDTH = NIBBLE_W * DIGITS;

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic [DIGITS:0]   lo_max;
    logic [DIGITS:0]   lo_min;
    logic [WIDTH-1:0]  load_clamped;
    logic [WIDTH-1:0]  count;
    logic              count_req_c;
    logic              limit_c;
    logic              go_c;
    logic              wrap_c;
    logic              clamp_hit_c;
    logic              carry_q;
    logic              load_err_q;

    // lo_max[i]/lo_min[i]: every digit below i sits at 9 / 0; index DIGITS covers the whole count.
    assign lo_max[0] = 1'b1;
    assign lo_min[0] = 1'b1;

    assign count_req_c = bus.en & ~bus.clear & ~bus.load;
    assign limit_c     = bus.up_down ? lo_max[DIGITS] : lo_min[DIGITS];
    assign go_c        = count_req_c & (WRAP | ~limit_c);
    assign wrap_c      = count_req_c & limit_c & WRAP;

    generate
        for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
            assign lo_max[i+1] = lo_max[i] & at_max[i];
            assign lo_min[i+1] = lo_min[i] & at_min[i];
            assign load_clamped[i*NIBBLE_W +: NIBBLE_W] =
                bcd_clamp(bus.load_value[i*NIBBLE_W +: NIBBLE_W]);
            assign step[i] = go_c & (bus.up_down ? lo_max[i] : lo_min[i]);

            bcd_digit u_digit (
                .clk     (clk),
                .rst_n   (rst_n),
                .step    (step[i]),
                .up_down (bus.up_down),
                .clear   (bus.clear),
                .load    (bus.load),
                .d       (load_clamped[i*NIBBLE_W +: NIBBLE_W]),
                .q       (count[i*NIBBLE_W +: NIBBLE_W]),
                .at_max  (at_max[i]),
                .at_min  (at_min[i])
            );
        end
    endgenerate

    // Flag any load nibble that needed clamping.
    always_comb begin
        clamp_hit_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.load_value[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX) begin
                clamp_hit_c = 1'b1;
            end
        end
    end

    // Single-cycle status pulses, aligned with the count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= wrap_c;
            load_err_q <= bus.load & ~bus.clear & clamp_hit_c;
        end
    end

    assign bus.bcd      = count;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
    assign bus.is_zero  = lo_min[DIGITS];
    assign bus.is_max   = lo_max[DIGITS];

endmodule : bcd_pulse_counter

// File: tb/tb_bcd_pulse_counter.sv
// Directed bench: a wrapping and a saturating 4-decade counter driven with identical stimulus.
module tb_bcd_pulse_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic carry_seen;

    bcd_pulse_counter_if #(.DIGITS(4)) if_w ();
    bcd_pulse_counter_if #(.DIGITS(4)) if_s ();

    bcd_pulse_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w)
    );

    bcd_pulse_counter #(.DIGITS(4), .WRAP(1'b0)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic ud, input logic c, input logic l,
                         input logic [15:0] lv);
        if_w.en = e; if_w.up_down = ud; if_w.clear = c; if_w.load = l; if_w.load_value = lv;
        if_s.en = e; if_s.up_down = ud; if_s.clear = c; if_s.load = l; if_s.load_value = lv;
    endtask

    // Apply one cycle of requests, then return inputs to idle 1 ns after the edge.
    task automatic cycle(input logic e, input logic ud, input logic c, input logic l,
                         input logic [15:0] lv);
        @(negedge clk);
        drive(e, ud, c, l, lv);
        @(posedge clk);
        #1;
        drive(1'b0, ud, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        #12;
        chk("rst_bcd_w",     if_w.bcd,      16'h0000);
        chk("rst_bcd_s",     if_s.bcd,      16'h0000);
        chk("rst_is_zero",   if_w.is_zero,  16'h0001);
        chk("rst_is_max",    if_w.is_max,   16'h0000);
        chk("rst_carry",     if_w.carry,    16'h0000);
        chk("rst_load_err",  if_w.load_err, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // en held high for 12 cycles gives 12 steps
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        carry_seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            carry_seen = carry_seen | if_w.carry | if_s.carry;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("up12_bcd_w",   if_w.bcd,     16'h0012);
        chk("up12_bcd_s",   if_s.bcd,     16'h0012);
        chk("up12_is_zero", if_w.is_zero, 16'h0000);
        chk("up12_carry",   carry_seen,   16'h0000);

        // decade ripple 0099 -> 0100
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0099);
        chk("ld99_bcd", if_w.bcd, 16'h0099);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("rip_bcd",   if_w.bcd,   16'h0100);
        chk("rip_carry", if_w.carry, 16'h0000);

        // upper limit
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        chk("ld9999_is_max", if_s.is_max, 16'h0001);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("upwrap_bcd_w",     if_w.bcd,     16'h0000);
        chk("upwrap_carry_w",   if_w.carry,   16'h0001);
        chk("upwrap_is_zero_w", if_w.is_zero, 16'h0001);
        chk("upsat_bcd_s",      if_s.bcd,     16'h9999);
        chk("upsat_carry_s",    if_s.carry,   16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("upwrap_carry_1cyc", if_w.carry, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("upsat3_bcd_s",    if_s.bcd,    16'h9999);
        chk("upsat3_is_max_s", if_s.is_max, 16'h0001);
        chk("upsat3_carry_s",  if_s.carry,  16'h0000);
        chk("after_wrap_w",    if_w.bcd,    16'h0002);

        // lower limit
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("dnwrap_bcd_w",   if_w.bcd,     16'h9999);
        chk("dnwrap_carry_w", if_w.carry,   16'h0001);
        chk("dnwrap_is_max",  if_w.is_max,  16'h0001);
        chk("dnsat_bcd_s",    if_s.bcd,     16'h0000);
        chk("dnsat_carry_s",  if_s.carry,   16'h0000);
        chk("dnsat_is_zero",  if_s.is_zero, 16'h0001);

        // borrow ripple 1000 -> 0999
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("borrow_bcd_w",  if_w.bcd,   16'h0999);
        chk("borrow_bcd_s",  if_s.bcd,   16'h0999);
        chk("borrow_carry",  if_w.carry, 16'h0000);

        // priority: clear > load > en
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        chk("prio_clr_bcd",   if_w.bcd,      16'h0000);
        chk("prio_clr_carry", if_w.carry,    16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
        chk("prio_ld_bcd",    if_w.bcd,      16'h1234);
        chk("prio_ld_err",    if_w.load_err, 16'h0000);

        // clamped load
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hA3F5);
        chk("clamp_bcd_w",  if_w.bcd,      16'h9395);
        chk("clamp_err_w",  if_w.load_err, 16'h0001);
        chk("clamp_err_s",  if_s.load_err, 16'h0001);
        chk("clamp_carry",  if_w.carry,    16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("clamp_err_1cyc", if_w.load_err, 16'h0000);

        // up_down toggling with en low changes nothing
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("ud_idle_bcd", if_w.bcd, 16'h9395);

        // asynchronous reset mid-count
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("pre_rst_bcd", if_w.bcd, 16'h0042);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bcd_w",  if_w.bcd,     16'h0000);
        chk("async_rst_bcd_s",  if_s.bcd,     16'h0000);
        chk("async_rst_zero",   if_w.is_zero, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_pulse_counter
